// File: rtl/reg_bank_pkg.sv
// Shared constants and the per-channel op-priority encoding for reg_bank.
// The increment feature is selected in reg_cell by the REG_BANK_INC_EN macro.
package reg_bank_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_NUM_CORES  = 4;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_WR    = 3'd2,
    OP_BCAST = 3'd3,
    OP_CLR   = 3'd4
  } op_e;

  // Highest-priority request wins: clear, broadcast, write, increment, hold.
  function automatic op_e sel_op(input logic clr, input logic bcast,
                                 input logic wr, input logic inc);
    if (clr)        return OP_CLR;
    else if (bcast) return OP_BCAST;
    else if (wr)    return OP_WR;
    else if (inc)   return OP_INC;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One register channel: priority mux, optional increment with wrap pulse, output gating.
// Increment/OVF logic is compiled in only when REG_BANK_INC_EN is defined.
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bcast,
  input  logic [DATA_WIDTH-1:0] bcast_data,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  ldbus,
  input  logic                  ldalu,
  output logic [DATA_WIDTH-1:0] bout,
  output logic [DATA_WIDTH-1:0] alu,
  output logic                  ovf,
  output logic                  zero,
  output op_e                   op
);

`ifdef REG_BANK_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] d;
  logic                  wrap;
  logic                  ovf_q;

  always_comb begin
    op   = sel_op(clr, bcast, wr, inc & INC_EN);
    d    = q;
    wrap = 1'b0;
    unique case (op)
      OP_CLR:   d = RESET_VAL;
      OP_BCAST: d = bcast_data;
      OP_WR:    d = wr_data;
      OP_INC: begin
        d    = q + DATA_WIDTH'(1);
        wrap = &q;
      end
      default:  d = q;
    endcase
  end

  // OVF is cleared every cycle unless this edge performed the wrap itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      q     <= d;
      ovf_q <= wrap;
    end
  end

`ifdef REG_BANK_INC_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0 & ovf_q;
`endif

  assign bout = ldbus ? q : '0;
  assign alu  = ldalu ? q : '0;
  assign zero = (q == '0);

endmodule

// File: rtl/reg_bank.sv
// Bank of NUM_CORES independent registers, one reg_cell per core; channel 0's BIN slice
// is the broadcast source. Define REG_BANK_INC_EN to enable INC/OVF.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    NUM_CORES  = DEFAULT_NUM_CORES,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] BIN,
  input  logic [NUM_CORES-1:0]            WR,
  input  logic [NUM_CORES-1:0]            INC,
  input  logic [NUM_CORES-1:0]            CLR,
  input  logic [NUM_CORES-1:0]            LDBUS,
  input  logic [NUM_CORES-1:0]            LDALU,
  input  logic                            BCAST,
  output logic [NUM_CORES*DATA_WIDTH-1:0] BOUT,
  output logic [NUM_CORES*DATA_WIDTH-1:0] ALU,
  output logic [NUM_CORES-1:0]            OVF,
  output logic [NUM_CORES-1:0]            ZERO,
  output op_e                             dbg_op [NUM_CORES]
);

  logic [DATA_WIDTH-1:0] bcast_data;
  assign bcast_data = BIN[DATA_WIDTH-1:0];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_cell
    reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL)
    ) u_cell (
      .clk        (clk),
      .rst        (RST),
      .bcast      (BCAST),
      .bcast_data (bcast_data),
      .wr         (WR[i]),
      .wr_data    (BIN[i*DATA_WIDTH +: DATA_WIDTH]),
      .inc        (INC[i]),
      .clr        (CLR[i]),
      .ldbus      (LDBUS[i]),
      .ldalu      (LDALU[i]),
      .bout       (BOUT[i*DATA_WIDTH +: DATA_WIDTH]),
      .alu        (ALU[i*DATA_WIDTH +: DATA_WIDTH]),
      .ovf        (OVF[i]),
      .zero       (ZERO[i]),
      .op         (dbg_op[i])
    );
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: reference model feeds an expected queue each edge.
// Expectations follow REG_BANK_INC_EN so the same bench covers both builds.
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int VW = 2*N*DW + 2*N;
  localparam logic [DW-1:0] RV = '0;
`ifdef REG_BANK_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] bin = '0;
  logic [N-1:0]    wr = '0, inc = '0, clr = '0, ldbus = '0, ldalu = '0;
  logic            bcast = 1'b0;
  logic [N*DW-1:0] bout, alu;
  logic [N-1:0]    ovf, zero;
  op_e             dbg_op [N];

  reg_bank #(.DATA_WIDTH(DW), .NUM_CORES(N), .RESET_VAL(RV)) dut (
    .clk(clk), .RST(rst), .BIN(bin), .WR(wr), .INC(inc), .CLR(clr),
    .LDBUS(ldbus), .LDALU(ldalu), .BCAST(bcast),
    .BOUT(bout), .ALU(alu), .OVF(ovf), .ZERO(zero), .dbg_op(dbg_op)
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard
  logic [DW-1:0] m_reg [N];
  logic [N-1:0]  m_ovf;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v, obs_v;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [VW-1:0] model_view();
    logic [N*DW-1:0] b, a;
    logic [N-1:0]    z;
    for (int i = 0; i < N; i++) begin
      b[i*DW +: DW] = ldbus[i] ? m_reg[i] : '0;
      a[i*DW +: DW] = ldalu[i] ? m_reg[i] : '0;
      z[i]          = (m_reg[i] == '0);
    end
    return {b, a, m_ovf, z};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = RV;
    m_ovf = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] nov;
    nov = '0;
    for (int i = 0; i < N; i++) begin
      if (clr[i])                m_reg[i] = RV;
      else if (bcast)            m_reg[i] = bin[DW-1:0];
      else if (wr[i])            m_reg[i] = bin[i*DW +: DW];
      else if (inc[i] && INC_EN) begin
        nov[i]   = (m_reg[i] == 16'hFFFF);
        m_reg[i] = m_reg[i] + 16'd1;
      end
    end
    m_ovf = nov;
  endtask

  // Wait for an edge, advance the model, queue the expected outputs, settle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    exp_q.push_back(model_view());
    #1;
  endtask

  task automatic drive(input logic [N-1:0] w, input logic [N-1:0] ic, input logic [N-1:0] c,
                       input logic b, input logic [N*DW-1:0] data,
                       input logic [N-1:0] lb, input logic [N-1:0] la);
    @(negedge clk);
    wr = w; inc = ic; clr = c; bcast = b; bin = data; ldbus = lb; ldalu = la;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr = '1; inc = '1; clr = '1; bcast = 1'b1; ldbus = '1; ldalu = '1;
    bin = {$urandom, $urandom};
    tick();
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL reset_sb: got %h expected %h", obs_v, exp_v);
    end
    n_checks++;
    if (bout !== '0 || zero !== 4'hF || ovf !== 4'h0) begin
      n_fail++; $display("FAIL reset_lit: bout=%h zero=%b ovf=%b expected 0/1111/0000", bout, zero, ovf);
    end
    @(negedge clk);
    rst = 1'b0; wr = '0; inc = '0; clr = '0; bcast = 1'b0; ldbus = '0; ldalu = '0;
  endtask

  task automatic test_write();
    drive(4'b0010, '0, '0, 1'b0, {16'd0, 16'd0, 16'd32, 16'd0}, 4'b0000, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL write_hidden: got %h expected %h", obs_v, exp_v);
    end
    drive('0, '0, '0, 1'b0, '0, 4'b0010, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL write_bus_sb: got %h expected %h", obs_v, exp_v);
    end
    n_checks++;
    if (bout !== 64'h0000_0000_0020_0000) begin
      n_fail++; $display("FAIL write_bus_lit: got %h expected 0000000000200000", bout);
    end
    drive(4'b0010, '0, '0, 1'b0, {16'd0, 16'd0, 16'd64, 16'd0}, 4'b0000, 4'b0010);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL write_alu_sb: got %h expected %h", obs_v, exp_v);
    end
    n_checks++;
    if (alu[31:16] !== 16'd64 || bout !== '0) begin
      n_fail++; $display("FAIL write_alu_lit: alu1=%h bout=%h expected 0040/0", alu[31:16], bout);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e1, e2;
    e1 = INC_EN ? 16'hFFFF : 16'hFFFE;
    e2 = INC_EN ? 16'h0000 : 16'hFFFE;
    drive(4'b0100, '0, '0, 1'b0, {16'd0, 16'hFFFE, 16'd0, 16'd0}, 4'b0100, 4'b0000);
    void'(exp_q.pop_front());
    drive('0, 4'b0100, '0, 1'b0, '0, 4'b0100, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[47:32] !== e1 || ovf[2] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_first: got %h expected %h (reg %h)", obs_v, exp_v, e1);
    end
    drive('0, 4'b0100, '0, 1'b0, '0, 4'b0100, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[47:32] !== e2 || ovf[2] !== INC_EN || zero[2] !== INC_EN) begin
      n_fail++; $display("FAIL wrap_zero: got %h expected %h (reg %h)", obs_v, exp_v, e2);
    end
    drive('0, '0, '0, 1'b0, '0, 4'b0100, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || ovf !== 4'h0) begin
      n_fail++; $display("FAIL wrap_ovf_drop: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_priority();
    drive(4'b0001, 4'b0001, 4'b0001, 1'b0, {48'd0, 16'd5}, 4'b0001, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL prio_clr: got %h expected %h", obs_v, exp_v);
    end
    drive(4'b0001, 4'b0001, '0, 1'b0, {48'd0, 16'd5}, 4'b0001, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[15:0] !== 16'd5) begin
      n_fail++; $display("FAIL prio_wr: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_bcast();
    drive(4'b0110, '0, 4'b1000, 1'b1, {16'h1111, 16'h2222, 16'h3333, 16'hA5A5}, 4'b1111, 4'b0101);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++; $display("FAIL bcast_sb: got %h expected %h", obs_v, exp_v);
    end
    n_checks++;
    if (bout !== 64'h0000_A5A5_A5A5_A5A5 || zero !== 4'b1000) begin
      n_fail++; $display("FAIL bcast_lit: bout=%h zero=%b expected 0000a5a5a5a5a5a5/1000", bout, zero);
    end
  endtask

  task automatic test_async_reset();
    drive(4'b0001, '0, '0, 1'b0, {48'd0, 16'd7}, 4'b0001, 4'b0000);
    void'(exp_q.pop_front());
    @(negedge clk);
    wr = '0; inc = 4'b0001;
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_view());
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL async_rst: got %h expected %h", obs_v, exp_v);
    end
    #1 rst = 1'b0;
    tick();
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[15:0] !== (INC_EN ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL rst_resume: got %h expected %h", obs_v, exp_v);
    end
    // Without the increment feature INC must hold a non-zero value.
    drive(4'b0001, '0, '0, 1'b0, {48'd0, 16'd7}, 4'b0001, 4'b0000);
    void'(exp_q.pop_front());
    drive('0, 4'b0001, '0, 1'b0, '0, 4'b0001, 4'b0000);
    exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
    n_checks++;
    if (obs_v !== exp_v || bout[15:0] !== (INC_EN ? 16'd8 : 16'd7) || ovf !== 4'h0) begin
      n_fail++; $display("FAIL inc_at7: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] c;
    for (int k = 0; k < 24; k++) begin
      c = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      drive(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), c,
            ($urandom_range(0, 7) == 0), {$urandom, $urandom},
            N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
      exp_v = exp_q.pop_front(); obs_v = {bout, alu, ovf, zero};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write();
    test_wrap();
    test_priority();
    test_bcast();
    test_async_reset();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each register.
REQ-002 SHALL have parameter NUM_CORES, default 4, legal range 1..16: number of independent register channels, one per core.
REQ-003 SHALL have parameter RESET_VAL, default 0: value loaded on reset and on CLR.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port BIN  input  NUM_CORES*DATA_WIDTH  per-channel write data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have ports WR, INC, CLR, LDBUS, LDALU  input  NUM_CORES each  per-channel write, increment, sync clear, bus-drive and ALU-drive enables.
REQ-008 SHALL have port BCAST  input  1  broadcast write of channel 0's BIN slice into every channel.
REQ-009 SHALL have ports BOUT, ALU  output  NUM_CORES*DATA_WIDTH  per-channel bus and ALU outputs, same slicing as BIN.
REQ-010 SHALL have ports OVF, ZERO  output  NUM_CORES each  per-channel increment-wrap pulse and register-equals-zero flag.

Function
REQ-011 Each channel SHALL hold one DATA_WIDTH register updated only on rising clk edges, except for RST.
REQ-012 Per-channel update priority SHALL be: CLR, then BCAST, then WR, then INC, then hold.
REQ-013 CLR SHALL load RESET_VAL at the next edge.
REQ-014 BCAST SHALL load BIN[DATA_WIDTH-1:0] into every channel not being cleared at the next edge.
REQ-015 WR SHALL load that channel's BIN slice at the next edge, with one cycle latency from WR to visibility on BOUT/ALU.
REQ-016 INC SHALL add 1 modulo 2^DATA_WIDTH; all-ones + 1 SHALL give 0.
REQ-017 OVF[i] SHALL be registered and high for exactly the one cycle following an edge at which INC[i] wrapped all-ones to 0, and low otherwise, including when a higher-priority op overrides INC.
REQ-018 BOUT slice SHALL equal the register when LDBUS[i]=1 and 0 otherwise, combinationally.
REQ-019 ALU slice SHALL equal the register when LDALU[i]=1 and 0 otherwise, combinationally; LDBUS and LDALU together SHALL drive both outputs.
REQ-020 ZERO[i] SHALL be combinational, high when the register equals 0.
REQ-021 Channels SHALL be fully independent, except for the BCAST source.

Reset
REQ-022 RST high SHALL immediately set every register to RESET_VAL and OVF to 0, regardless of clk.
REQ-023 While RST is high all ops SHALL be ignored; BOUT/ALU gating SHALL still apply to RESET_VAL.
REQ-024 Deasserting RST mid-sequence SHALL resume normal ops at the first subsequent rising edge, with no pending op carried over.

Configuration
REQ-025 Macro REG_BANK_INC_EN SHALL compile INC/OVF logic in; when defined, behaviour is per REQ-016/017.
REQ-026 Without REG_BANK_INC_EN, INC SHALL be ignored (treated as hold) and OVF SHALL be tied to 0; ports SHALL remain present.

Structure
REQ-027 Package reg_bank_pkg SHALL hold DEFAULT_DATA_WIDTH, DEFAULT_NUM_CORES and the op-priority encoding (OP_HOLD, OP_INC, OP_WR, OP_BCAST, OP_CLR).
REQ-028 A sub-module reg_cell (one channel: register, priority mux, increment, OVF, output gating) SHALL be instantiated NUM_CORES times by a generate loop.

Verification
REQ-029 Assert RST with ops active -> all registers 16'd0, OVF=0, ZERO all 1; with LDBUS=1, BOUT reads 0.
REQ-030 WR[1]=1, BIN slice1=16'd32; next cycle LDBUS[1]=1 -> BOUT slice1=32 and other slices 0; then WR[1] with 64 and LDALU[1]=1 -> ALU slice1=64.
REQ-031 WR[2] with 16'hFFFE, then INC[2] on two edges -> values FFFF then 0000, OVF[2] high exactly one cycle after the wrap, ZERO[2]=1.
REQ-032 WR[0]=INC[0]=CLR[0]=1 with BIN 16'd5 -> register 0; next cycle WR[0]=INC[0]=1 with BIN 16'd5 -> register 5 (WR beats INC).
REQ-033 BCAST=1, BIN slice0=16'hA5A5, CLR[3]=1 -> channels 0..2 = A5A5, channel 3 = 0.
REQ-034 Pulse RST mid-clock-low while INC active at value 7 -> register 0 immediately, next edge after release increments to 1; build without REG_BANK_INC_EN -> INC holds value, OVF stays 0.
